// File: rtl/mixer_pkg.sv
// Shared constants and helpers for the voice mixer: register map, unity gain
// and width-parameterised saturation.
package mixer_pkg;

    localparam logic [7:0] MIXER_GAIN_BASE = 8'h00;
    localparam logic [7:0] MIXER_SHIFT     = 8'h40;
    localparam logic [7:0] MIXER_CLEAR     = 8'h41;

    function automatic int unsigned unity_gain(input int unsigned gain_width);
        return 32'd1 << (gain_width - 1);
    endfunction

    // Clamp a sign-extended value to the signed range of `width` bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Bundles the core subsample stream, the config write bus and the sample
// output handshake of the voice mixer.
interface voice_mixer_if #(
    parameter int NUM_VOICES      = 16,
    parameter int SUBSAMPLE_WIDTH = 16,
    parameter int SAMPLE_WIDTH    = 16
);
    localparam int VOICE_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic signed [SUBSAMPLE_WIDTH-1:0] subsample;
    logic                              subsample_valid;
    logic [VOICE_WIDTH-1:0]            subsample_voice;
    logic                              subsample_last;
    logic                              reg_write_enable;
    logic [7:0]                        reg_address;
    logic [15:0]                       reg_value;
    logic signed [SAMPLE_WIDTH-1:0]    sample;
    logic                              sample_valid;
    logic                              sample_ready;
    logic                              clipped;
    logic                              overrun;

    modport master (
        output subsample, subsample_valid, subsample_voice, subsample_last,
        output reg_write_enable, reg_address, reg_value, sample_ready,
        input  sample, sample_valid, clipped, overrun
    );

    modport slave (
        input  subsample, subsample_valid, subsample_voice, subsample_last,
        input  reg_write_enable, reg_address, reg_value, sample_ready,
        output sample, sample_valid, clipped, overrun
    );

endinterface

// File: rtl/voice_mixer_sample_fifo.sv
// Small synchronous FIFO with a registered head; callers present only
// qualified push/pop requests.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int COUNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_next;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [WIDTH-1:0]       head_next;

    assign full  = (count == COUNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

    // The head register tracks whichever element will be at the front after
    // this edge; a push into an empty (or emptying) FIFO bypasses the array.
    always_comb begin
        rd_next    = rd_ptr + PTR_WIDTH'(pop);
        count_next = count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
        head_next  = head;
        if (count_next != '0) begin
            if (push && (count == '0 || (pop && count == COUNT_WIDTH'(1)))) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_ptr + PTR_WIDTH'(push);
            count  <= count_next;
            head   <= head_next;
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Per-voice gain, frame accumulation, master shift and saturation of core
// subsamples into one output sample per frame, queued for the DAC side.
module voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES      = 16,
    parameter int SUBSAMPLE_WIDTH = 16,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int GAIN_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input logic        i_Clock,
    input logic        i_Reset,
    voice_mixer_if.slave bus
);
    localparam int VOICE_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int P_WIDTH     = SUBSAMPLE_WIDTH + 1;
    localparam int PROD_WIDTH  = SUBSAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int ACC_WIDTH   = SUBSAMPLE_WIDTH + 1 + $clog2(NUM_VOICES);
    localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY  = GAIN_WIDTH'(unity_gain(GAIN_WIDTH));
    localparam logic [3:0]            SHIFT_RESET = 4'($clog2(NUM_VOICES));

    logic [GAIN_WIDTH-1:0]          gain [NUM_VOICES];
    logic [3:0]                     master_shift;
    logic [GAIN_WIDTH-1:0]          voice_gain;
    logic [7:0]                     gain_offset;
    logic signed [PROD_WIDTH-1:0]   product;
    logic signed [PROD_WIDTH-1:0]   product_scaled;
    logic signed [P_WIDTH-1:0]      p_q;
    logic                           p_valid_q;
    logic                           p_last_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    acc_sum;
    logic signed [ACC_WIDTH-1:0]    acc_shifted;
    logic signed [63:0]             sat_wide;
    logic signed [SAMPLE_WIDTH-1:0] sample_sat;
    logic                           frame_done;
    logic                           clip_event;
    logic                           overrun_event;
    logic                           clear_clip;
    logic                           clear_overrun;
    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [SAMPLE_WIDTH-1:0]        fifo_head;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;
    logic                           clipped_q;
    logic                           overrun_q;

    // Out-of-range voice indices mix at gain 0.
    always_comb begin
        voice_gain = '0;
        if (int'(bus.subsample_voice) < NUM_VOICES) begin
            voice_gain = gain[bus.subsample_voice];
        end
    end

    assign product        = PROD_WIDTH'(bus.subsample) * PROD_WIDTH'($signed({1'b0, voice_gain}));
    assign product_scaled = product >>> (GAIN_WIDTH - 1);

    assign acc_sum     = acc_q + ACC_WIDTH'(p_q);
    assign acc_shifted = acc_sum >>> master_shift;
    assign sat_wide    = saturate(64'(acc_shifted), SAMPLE_WIDTH);
    assign sample_sat  = sat_wide[SAMPLE_WIDTH-1:0];

    assign frame_done    = p_valid_q && p_last_q;
    assign clip_event    = frame_done && (sat_wide != 64'(acc_shifted));
    assign fifo_pop      = bus.sample_ready && !fifo_empty;
    assign fifo_push     = frame_done && (!fifo_full || fifo_pop);
    assign overrun_event = frame_done && !fifo_push;

    assign gain_offset   = bus.reg_address - MIXER_GAIN_BASE;
    assign clear_clip    = bus.reg_write_enable && (bus.reg_address == MIXER_CLEAR) && bus.reg_value[0];
    assign clear_overrun = bus.reg_write_enable && (bus.reg_address == MIXER_CLEAR) && bus.reg_value[1];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                gain[v] <= GAIN_UNITY;
            end
            master_shift <= SHIFT_RESET;
            p_q          <= '0;
            p_valid_q    <= 1'b0;
            p_last_q     <= 1'b0;
            acc_q        <= '0;
            clipped_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            p_valid_q <= bus.subsample_valid;
            if (bus.subsample_valid) begin
                p_q      <= product_scaled[P_WIDTH-1:0];
                p_last_q <= bus.subsample_last;
            end
            if (p_valid_q) begin
                acc_q <= p_last_q ? '0 : acc_sum;
            end
            if (bus.reg_write_enable) begin
                if (gain_offset < 8'(NUM_VOICES)) begin
                    gain[gain_offset[VOICE_WIDTH-1:0]] <= bus.reg_value[GAIN_WIDTH-1:0];
                end else if (bus.reg_address == MIXER_SHIFT) begin
                    master_shift <= bus.reg_value[3:0];
                end
            end
            // A new event in the same cycle as a clear leaves the flag set.
            clipped_q <= (clipped_q && !clear_clip) || clip_event;
            overrun_q <= (overrun_q && !clear_overrun) || overrun_event;
        end
    end

    sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .push      (fifo_push),
        .push_data (sample_sat),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.sample       = fifo_head;
    assign bus.sample_valid = !fifo_empty;
    assign bus.clipped      = clipped_q;
    assign bus.overrun      = overrun_q;

    logic unused_bits;
    assign unused_bits = ^{fifo_count, product_scaled[PROD_WIDTH-1:P_WIDTH],
                           sat_wide[63:SAMPLE_WIDTH], bus.reg_value[15:GAIN_WIDTH]};

endmodule

// File: tb/tb_voice_mixer.sv
// Randomised scoreboard bench for voice_mixer: a frame-level reference model
// predicts queued samples and sticky flags; a monitor checks every pop.
module tb_voice_mixer;
    localparam int NV = 16;
    localparam int SW = 16;
    localparam int OW = 16;
    localparam int GW = 8;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    voice_mixer_if #(.NUM_VOICES(NV), .SUBSAMPLE_WIDTH(SW), .SAMPLE_WIDTH(OW)) bus ();

    voice_mixer #(
        .NUM_VOICES(NV), .SUBSAMPLE_WIDTH(SW), .SAMPLE_WIDTH(OW),
        .GAIN_WIDTH(GW), .FIFO_DEPTH(FD)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ready = 1'b0;

    // Reference model state
    longint m_gain [NV];
    longint m_shift;
    longint m_frame;
    bit     m_pend;
    longint m_pend_val;
    bit     m_pend_clip;
    int     m_occ;
    bit     m_clip;
    bit     m_ovr;
    longint exp_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Frame-level model: a sample's value is the floor-scaled, clamped sum of
    // gained subsamples; it lands in the queue one edge after the last one.
    always @(posedge clk) begin : model
        bit     pop;
        longint g;
        longint p;
        longint s;
        int     v;
        if (rst) begin
            for (int i = 0; i < NV; i++) m_gain[i] = 128;
            m_shift = 4;
            m_frame = 0;
            m_pend  = 0;
            m_occ   = 0;
            m_clip  = 0;
            m_ovr   = 0;
            exp_q.delete();
        end else begin
            pop = bus.sample_ready && (m_occ > 0);
            if (bus.reg_write_enable && bus.reg_address == 8'h41) begin
                if (bus.reg_value[0]) m_clip = 0;
                if (bus.reg_value[1]) m_ovr = 0;
            end
            if (m_pend) begin
                if (m_pend_clip) m_clip = 1;
                if (m_occ < FD || pop) begin
                    exp_q.push_back(m_pend_val);
                    m_occ++;
                end else begin
                    m_ovr = 1;
                end
            end
            if (pop) m_occ--;
            m_pend = 0;
            if (bus.subsample_valid) begin
                v = int'(bus.subsample_voice);
                g = (v < NV) ? m_gain[v] : 0;
                p = (longint'(bus.subsample) * g) >>> (GW - 1);
                m_frame += p;
                if (bus.subsample_last) begin
                    s = m_frame >>> m_shift;
                    m_pend_clip = (s > 32767) || (s < -32768);
                    m_pend_val  = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
                    m_pend  = 1;
                    m_frame = 0;
                end
            end
            if (bus.reg_write_enable) begin
                if (bus.reg_address < 8'(NV)) m_gain[bus.reg_address] = longint'(bus.reg_value[GW-1:0]);
                else if (bus.reg_address == 8'h40) m_shift = longint'(bus.reg_value[3:0]);
            end
        end
    end

    always @(negedge clk) begin : monitor
        if (!rst) begin
            check("sample_valid", bus.sample_valid, (m_occ > 0) ? 1 : 0);
            check("clipped", bus.clipped, m_clip);
            check("overrun", bus.overrun, m_ovr);
            if (bus.sample_valid && bus.sample_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sample_unexpected: got %0d, expected no sample", bus.sample);
                end else begin
                    check("sample", bus.sample, exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_ready) bus.sample_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input bit v, input int voice, input logic [15:0] val, input bit last,
                         input bit we, input logic [7:0] addr, input logic [15:0] data);
        bus.subsample_valid  = v;
        bus.subsample_voice  = 4'(voice);
        bus.subsample        = val;
        bus.subsample_last   = last;
        bus.reg_write_enable = we;
        bus.reg_address      = addr;
        bus.reg_value        = data;
        cyc();
        bus.subsample_valid  = 1'b0;
        bus.subsample_last   = 1'b0;
        bus.reg_write_enable = 1'b0;
    endtask

    task automatic sub(input int voice, input logic [15:0] val, input bit last);
        drive(1'b1, voice, val, last, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [15:0] data);
        drive(1'b0, 0, 16'h0000, 1'b0, 1'b1, addr, data);
    endtask

    task automatic frame_const(input int n, input logic [15:0] val);
        for (int v = 0; v < n; v++) sub(v, val, v == n - 1);
    endtask

    task automatic restore_defaults();
        for (int v = 0; v < NV; v++) wr(8'(v), 16'h0080);
        wr(8'h40, 16'd4);
    endtask

    task automatic expect_head(input string name, input longint val);
        int i;
        i = 0;
        while (!bus.sample_valid && i < 10) begin
            cyc();
            i++;
        end
        check({name, "_valid"}, bus.sample_valid, 1);
        check(name, bus.sample, val);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        bus.sample_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || m_occ != 0 || m_pend); i++) cyc();
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", bus.sample_valid, 0);
        bus.sample_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit we;
        int len;
        rst = 1'b1;
        bus.subsample_valid = 1'b0; bus.subsample_voice = '0; bus.subsample = '0;
        bus.subsample_last = 1'b0; bus.reg_write_enable = 1'b0; bus.reg_address = '0;
        bus.reg_value = '0; bus.sample_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        check("reset_valid", bus.sample_valid, 0);
        check("reset_sample", bus.sample, 0);
        check("reset_clipped", bus.clipped, 0);
        check("reset_overrun", bus.overrun, 0);

        // Unity mix and output latency
        frame_const(16, 16'h1000);
        check("unity_latency_early", bus.sample_valid, 0);
        cyc();
        check("unity_latency_valid", bus.sample_valid, 1);
        check("unity_sample", bus.sample, 16'h1000);
        check("unity_clipped", bus.clipped, 0);
        drain();

        // Per-voice gains, shift 0
        wr(8'h03, 16'h0000);
        wr(8'h00, 16'h00FF);
        wr(8'h40, 16'h0000);
        sub(0, 16'h0100, 1'b0);
        sub(1, 16'h0010, 1'b0);
        sub(2, 16'h0010, 1'b0);
        sub(3, 16'h7FFF, 1'b1);
        expect_head("gain_mix", 16'h021E);
        drain();

        // Saturation in both directions, then clear
        for (int v = 0; v < NV; v++) wr(8'(v), 16'h00FF);
        frame_const(16, 16'h7FFF);
        expect_head("sat_pos", 32767);
        check("sat_clipped", bus.clipped, 1);
        drain();
        frame_const(16, 16'h8000);
        expect_head("sat_neg", -32768);
        drain();
        wr(8'h41, 16'h0001);
        check("clip_cleared", bus.clipped, 0);
        restore_defaults();

        // Backpressure: five frames into a four-deep FIFO
        for (int f = 1; f <= 5; f++) frame_const(16, 16'(f));
        cyc(); cyc();
        check("ovr_set", bus.overrun, 1);
        expect_head("ovr_head", 1);
        drain();
        wr(8'h41, 16'h0002);
        check("ovr_cleared", bus.overrun, 0);
        for (int f = 0; f < 4; f++) sub(0, 16'h0100, 1'b1);
        cyc(); cyc();
        sub(0, 16'h0200, 1'b1);
        bus.sample_ready = 1'b1;
        cyc();
        bus.sample_ready = 1'b0;
        check("full_push_pop_no_ovr", bus.overrun, 0);
        drain();

        // Gain write racing a subsample of the same voice
        wr(8'h40, 16'h0000);
        drive(1'b1, 2, 16'h1000, 1'b1, 1'b1, 8'h02, 16'h0000);
        expect_head("race_old_gain", 16'h1000);
        drain();
        sub(2, 16'h1000, 1'b1);
        expect_head("race_new_gain", 0);
        drain();

        // Reset mid-frame with two queued samples and a sticky flag set
        wr(8'h00, 16'h00FF);
        sub(0, 16'h7FFF, 1'b1);
        sub(0, 16'h0100, 1'b1);
        cyc(); cyc();
        check("pre_reset_clipped", bus.clipped, 1);
        for (int v = 0; v < 8; v++) sub(v, 16'h1000, 1'b0);
        do_reset();
        check("mid_reset_valid", bus.sample_valid, 0);
        check("mid_reset_sample", bus.sample, 0);
        check("mid_reset_clipped", bus.clipped, 0);
        check("mid_reset_overrun", bus.overrun, 0);
        frame_const(16, 16'h1000);
        expect_head("post_reset_frame", 16'h1000);
        drain();

        // Randomised frames, config traffic and consumer stalls
        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(1, 16);
            if ($urandom_range(0, 3) == 0) wr(8'h40, 16'($urandom_range(0, 6)));
            if ($urandom_range(0, 2) == 0) wr(8'($urandom_range(0, 17)), 16'($urandom));
            for (int k = 0; k < len; k++) begin
                we = ($urandom_range(0, 7) == 0);
                drive(1'b1, $urandom_range(0, 15), 16'($urandom), k == len - 1,
                      we, 8'($urandom_range(0, 16)), 16'($urandom));
                if ($urandom_range(0, 5) == 0) cyc();
            end
            if ($urandom_range(0, 9) == 0) wr(8'h41, 16'($urandom_range(0, 3)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
